// File: rtl/fsk_rx_frame_ctrl_pkg.sv
// fsk_rx_frame_ctrl_pkg: shared state encoding, default word width and parity mode for the FSK frame receiver.
package fsk_rx_frame_ctrl_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, HUNT = 3'd1, DATA = 3'd2, PAR = 3'd3, STOP = 3'd4} state_t;
  localparam int DW_DEFAULT = 8;
`ifdef FSK_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
endpackage

// File: rtl/fsk_rx_frame_ctrl_if.sv
// fsk_rx_frame_ctrl_if: demodulator strobes in, received-word valid/ready stream out.
interface fsk_rx_frame_ctrl_if
  import fsk_rx_frame_ctrl_pkg::*;
#(parameter int DW = DW_DEFAULT);
  logic fsk_start;
  logic fsk_res;
  logic ok_rx_bit;
  logic rx_bit;
  logic [DW-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  modport slave (input fsk_start, fsk_res, ok_rx_bit, rx_bit, rx_ready, output rx_data, rx_valid);
  modport master (output fsk_start, fsk_res, ok_rx_bit, rx_bit, rx_ready, input rx_data, rx_valid);
endinterface

// File: rtl/fsk_rx_frame_ctrl_fifo.sv
// fsk_rx_fifo: synchronous FIFO; a push to a full FIFO lands only when a pop frees the slot in the same clk.
module fsk_rx_fifo #(
  parameter int DW = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DW-1:0]                 wdata,
  input  logic                          pop,
  output logic [DW-1:0]                 rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [DW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic wr_en, rd_en;
  assign full  = level_q == (AW+1)'(FIFO_DEPTH);
  assign empty = level_q == '0;
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign rdata = empty ? '0 : mem_q[rd_q];
  assign level = level_q;
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q] = wdata;
    wr_d    = wr_q + AW'(wr_en);
    rd_d    = rd_q + AW'(rd_en);
    level_d = level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/fsk_rx_frame_ctrl.sv
// fsk_rx_frame_ctrl: UART-style frame FSM over demodulator bit strobes, output FIFO and error counting.
// Define FSK_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fsk_rx_frame_ctrl
  import fsk_rx_frame_ctrl_pkg::*;
#(
  parameter int DW         = DW_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int ERRW       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  fsk_rx_frame_ctrl_if.slave           bus,
  output logic                         busy,
  output logic                         frame_err,
  output logic                         overrun,
  output logic [ERRW-1:0]              err_cnt,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam int CW = $clog2(DW + 1);
`ifdef FSK_RX_PARITY_EN
  localparam state_t LAST = PAR;
`else
  localparam state_t LAST = STOP;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;
  logic par_q, par_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic push, pop, full, empty, in_frame;
  assign in_frame = state_q inside {DATA, PAR, STOP};
  assign pop      = bus.rx_valid & bus.rx_ready;
  // par_q accumulates the XOR of data and parity bits; it stays 0 without the parity feature
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    if (bus.fsk_start) begin
      state_d     = HUNT;
      frame_err_d = in_frame;
    end else if (bus.fsk_res) begin
      state_d     = IDLE;
      frame_err_d = in_frame;
    end else if (bus.ok_rx_bit) begin
      case (state_q)
        HUNT: begin
          state_d   = bus.rx_bit ? HUNT : DATA;
          bit_cnt_d = '0;
          par_d     = 1'b0;
        end
        DATA: begin
          shreg_d   = DW'({bus.rx_bit, shreg_q} >> 1);
          bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef FSK_RX_PARITY_EN
          par_d     = par_q ^ bus.rx_bit;
`endif
          state_d   = (bit_cnt_q == CW'(DW - 1)) ? LAST : DATA;
        end
`ifdef FSK_RX_PARITY_EN
        PAR: begin
          par_d   = par_q ^ bus.rx_bit;
          state_d = STOP;
        end
`endif
        STOP: begin
          state_d     = HUNT;
          push        = bus.rx_bit & ~par_q;
          frame_err_d = ~(bus.rx_bit & ~par_q);
        end
        default: ;
      endcase
    end
    overrun_d = push & full & ~pop;
    err_cnt_d = ((frame_err_d | overrun_d) && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
  fsk_rx_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (shreg_q),
    .pop   (pop),
    .rdata (bus.rx_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );
  assign bus.rx_valid = ~empty;
  assign busy         = state_q != IDLE;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;
  assign err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_fsk_rx_frame_ctrl.sv
// tb_fsk_rx_frame_ctrl: directed frames against hand-computed words, error pulses and FIFO levels.
module tb_fsk_rx_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, frame_err, overrun;
  logic [7:0] err_cnt;
  logic [2:0] fifo_level;
  logic [7:0] got [$];
  int n_chk = 0;
  int n_fail = 0;

  fsk_rx_frame_ctrl_if #(.DW(8)) bus ();

  fsk_rx_frame_ctrl #(.DW(8), .FIFO_DEPTH(4), .ERRW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_cnt    (err_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && bus.rx_valid && bus.rx_ready) got.push_back(bus.rx_data);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic r, input logic o, input logic b);
    bus.fsk_start = s;
    bus.fsk_res   = r;
    bus.ok_rx_bit = o;
    bus.rx_bit    = b;
    tick();
    bus.fsk_start = 1'b0;
    bus.fsk_res   = 1'b0;
    bus.ok_rx_bit = 1'b0;
    bus.rx_bit    = 1'b0;
  endtask

  task automatic bitx(input logic b);
    send(1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic pre(input logic [7:0] d);
    bitx(1'b0);
    for (int i = 0; i < 8; i++) bitx(d[i]);
`ifdef FSK_RX_PARITY_EN
    bitx(^d);
`endif
  endtask

  task automatic frame(input logic [7:0] d, input logic stop);
    pre(d);
    bitx(stop);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    got.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
    n_chk++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    n_chk++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.rx_valid); end
    n_chk++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", bus.rx_data); end
  endtask

  task automatic test_basic();
    do_reset();
    send(1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b exp 1", busy); end
    pre(8'h5A);
    n_chk++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b exp 0", bus.rx_valid); end
    bitx(1'b1);
    n_chk++; if (bus.rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", bus.rx_valid); end
    n_chk++; if (bus.rx_data !== 8'h5A) begin n_fail++; $display("FAIL basic_data got %h exp 5a", bus.rx_data); end
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_frame_err got %b exp 0", frame_err); end
    n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL basic_err_cnt got %0d exp 0", err_cnt); end
    n_chk++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL basic_level got %0d exp 1", fifo_level); end
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    n_chk++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL basic_pop_level got %0d exp 0", fifo_level); end
    send(1'b0, 1'b1, 1'b0, 1'b0);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_res_busy got %b exp 0", busy); end
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_res_err got %b exp 0", frame_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.rx_ready = 1'b1;
    send(1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'hA5, 1'b1);
    repeat (3) bitx(1'b1);
    frame(8'h3C, 1'b1);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b exp 1", busy); end
    send(1'b0, 1'b1, 1'b0, 1'b0);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_res_busy got %b exp 0", busy); end
    tick();
    tick();
    n_chk++; if (got.size() !== 2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", got.size()); end
    n_chk++; if (got.size() < 1 || got[0] !== 8'hA5) begin n_fail++; $display("FAIL b2b_word0 got %h exp a5", got.size() > 0 ? got[0] : 8'hxx); end
    n_chk++; if (got.size() < 2 || got[1] !== 8'h3C) begin n_fail++; $display("FAIL b2b_word1 got %h exp 3c", got.size() > 1 ? got[1] : 8'hxx); end
  endtask

  task automatic test_bad_stop();
    do_reset();
    bus.rx_ready = 1'b1;
    send(1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'h11, 1'b0);
    n_chk++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL badstop_pulse got %b exp 1", frame_err); end
    n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL badstop_err_cnt got %0d exp 1", err_cnt); end
    n_chk++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL badstop_level got %0d exp 0", fifo_level); end
    tick();
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL badstop_pulse_end got %b exp 0", frame_err); end
    frame(8'h22, 1'b1);
    tick();
    tick();
    n_chk++; if (got.size() !== 1 || got[0] !== 8'h22) begin n_fail++; $display("FAIL badstop_next got %0d words first %h exp 1 word 22", got.size(), got.size() > 0 ? got[0] : 8'hxx); end
    n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL badstop_err_hold got %0d exp 1", err_cnt); end
  endtask

  task automatic test_truncation();
    do_reset();
    send(1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'h33, 1'b1);
    bitx(1'b0);
    repeat (4) bitx(1'b1);
    send(1'b0, 1'b1, 1'b0, 1'b0);
    n_chk++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL trunc_pulse got %b exp 1", frame_err); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL trunc_busy got %b exp 0", busy); end
    n_chk++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL trunc_level got %0d exp 1", fifo_level); end
    n_chk++; if (bus.rx_data !== 8'h33) begin n_fail++; $display("FAIL trunc_data got %h exp 33", bus.rx_data); end
    n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL trunc_err_cnt got %0d exp 1", err_cnt); end
  endtask

  task automatic test_overrun();
    do_reset();
    send(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) frame(8'(i), 1'b1);
    n_chk++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovr_full_level got %0d exp 4", fifo_level); end
    n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early got %b exp 0", overrun); end
    frame(8'h05, 1'b1);
    n_chk++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse got %b exp 1", overrun); end
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ovr_frame_err got %b exp 0", frame_err); end
    n_chk++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovr_level got %0d exp 4", fifo_level); end
    n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL ovr_err_cnt got %0d exp 1", err_cnt); end
    tick();
    n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pulse_end got %b exp 0", overrun); end
    bus.rx_ready = 1'b1;
    repeat (6) tick();
    n_chk++; if (got.size() !== 4) begin n_fail++; $display("FAIL ovr_drain_count got %0d exp 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (got.size() <= i || got[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL ovr_drain_word%0d got %h exp %h", i, got.size() > i ? got[i] : 8'hxx, 8'(i + 1)); end
    end
    do_reset();
    send(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) frame(8'(i), 1'b1);
    pre(8'h05);
    bus.rx_ready = 1'b1;
    bitx(1'b1);
    n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pop_pulse got %b exp 0", overrun); end
    n_chk++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovr_pop_level got %0d exp 4", fifo_level); end
    n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL ovr_pop_err_cnt got %0d exp 0", err_cnt); end
    repeat (6) tick();
    n_chk++; if (got.size() !== 5) begin n_fail++; $display("FAIL ovr_pop_count got %0d exp 5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (got.size() <= i || got[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL ovr_pop_word%0d got %h exp %h", i, got.size() > i ? got[i] : 8'hxx, 8'(i + 1)); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'h11, 1'b0);
    frame(8'h44, 1'b1);
    bitx(1'b0);
    bitx(1'b1);
    bitx(1'b0);
    n_chk++; if (busy !== 1'b1 || fifo_level !== 3'd1 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL mid_pre busy %b level %0d err %0d exp 1 1 1", busy, fifo_level, err_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b exp 0", busy); end
    n_chk++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL mid_level got %0d exp 0", fifo_level); end
    n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_err_cnt got %0d exp 0", err_cnt); end
    n_chk++; if (bus.rx_valid !== 1'b0 || bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL mid_out valid %b data %h exp 0 00", bus.rx_valid, bus.rx_data); end
    send(1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'h7E, 1'b1);
    n_chk++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h7E) begin n_fail++; $display("FAIL mid_next valid %b data %h exp 1 7e", bus.rx_valid, bus.rx_data); end
  endtask

  task automatic test_collisions();
    do_reset();
    send(1'b1, 1'b1, 1'b0, 1'b0);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL coll_start_wins got busy %b exp 1", busy); end
    pre(8'h55);
    send(1'b0, 1'b1, 1'b1, 1'b1);
    n_chk++; if (frame_err !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) begin n_fail++; $display("FAIL coll_res_wins err %b busy %b level %0d exp 1 0 0", frame_err, busy, fifo_level); end
    send(1'b1, 1'b0, 1'b0, 1'b0);
    bitx(1'b0);
    bitx(1'b1);
    send(1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++; if (frame_err !== 1'b1 || busy !== 1'b1 || err_cnt !== 8'd2) begin n_fail++; $display("FAIL coll_resync err %b busy %b cnt %0d exp 1 1 2", frame_err, busy, err_cnt); end
    frame(8'h96, 1'b1);
    n_chk++; if (bus.rx_data !== 8'h96 || fifo_level !== 3'd1) begin n_fail++; $display("FAIL coll_after data %h level %0d exp 96 1", bus.rx_data, fifo_level); end
  endtask

`ifdef FSK_RX_PARITY_EN
  task automatic test_parity();
    do_reset();
    send(1'b1, 1'b0, 1'b0, 1'b0);
    bitx(1'b0);
    for (int i = 0; i < 8; i++) bitx(i < 3);
    bitx(1'b1);
    bitx(1'b1);
    n_chk++; if (bus.rx_data !== 8'h07 || fifo_level !== 3'd1 || frame_err !== 1'b0) begin n_fail++; $display("FAIL par_good data %h level %0d err %b exp 07 1 0", bus.rx_data, fifo_level, frame_err); end
    bitx(1'b0);
    for (int i = 0; i < 8; i++) bitx(i < 3);
    bitx(1'b0);
    bitx(1'b1);
    n_chk++; if (frame_err !== 1'b1 || fifo_level !== 3'd1 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL par_bad err %b level %0d cnt %0d exp 1 1 1", frame_err, fifo_level, err_cnt); end
    bitx(1'b0);
    for (int i = 0; i < 8; i++) bitx(i < 3);
    bitx(1'b0);
    bitx(1'b0);
    n_chk++; if (frame_err !== 1'b1 || err_cnt !== 8'd2) begin n_fail++; $display("FAIL par_bad_stop err %b cnt %0d exp 1 2", frame_err, err_cnt); end
  endtask
`endif

  initial begin
    bus.fsk_start = 1'b0;
    bus.fsk_res   = 1'b0;
    bus.ok_rx_bit = 1'b0;
    bus.rx_bit    = 1'b0;
    bus.rx_ready  = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_bad_stop();
    test_truncation();
    test_overrun();
    test_reset_mid();
    test_collisions();
`ifdef FSK_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
